// File: rtl/uart_rx_module.sv
// uart_rx_module
//   8N1 UART receiver. rx_pin goes through a two-flop synchronizer. Each bit
//   is sampled at its mid-point, counted from the start-bit falling edge.
//   A good frame updates rx_data and pulses rx_done_sig for one clk.
//   A low stop bit pulses frame_err instead and leaves rx_data alone.
// Ports
//   clk          in   system clock, posedge
//   rst          in   async reset, active-high
//   rx_en_sig    in   receiver enable (low forces IDLE)
//   rx_pin       in   async serial input, idle high
//   rx_data      out  last good byte
//   rx_done_sig  out  1-clk pulse, rx_data updated this cycle
//   frame_err    out  1-clk pulse, stop bit sampled low
module uart_rx_module #(
  parameter logic [15:0] BPS = 16'd434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en_sig,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       frame_err
);

  localparam logic [15:0] HALF = BPS >> 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sync1_q, rx_s_q, rx_d_q;
  logic        fe;

  // Sync chain resets to the idle-high level so reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  assign fe = rx_d_q & ~rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // cnt is 0 in the first cycle after the edge, so sample 0 lands at
  // cnt==HALF-1. After that each sample lands at cnt==BPS-1, and cnt
  // wraps to 0 at every sample point.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!rx_en_sig) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (fe) state_d = START;
        end
        START: begin
          if (cnt_q == HALF - 16'd1) begin
            cnt_d = '0;
            idx_d = '0;
            // A start bit that is high again at mid-point was a glitch.
            state_d = rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == BPS - 16'd1) begin
            cnt_d          = '0;
            shift_d[idx_q] = rx_s_q;
            if (idx_q == 3'd7) state_d = STOP;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        STOP: begin
          if (cnt_q == BPS - 16'd1) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BREAK;
            end
          end
        end
        BREAK: begin
          // A line held low must go high before the next edge can arm IDLE.
          cnt_d = '0;
          if (rx_s_q) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rx_data     = data_q;
  assign rx_done_sig = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_uart_rx_module.sv
module tb_uart_rx_module;

  localparam int P = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en_sig;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       frame_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_pulse = 0;
  int start_cyc = 0;
  int done_cyc[$];
  logic done_prev = 1'b0, err_prev = 1'b0;

  uart_rx_module #(.BPS(16'd434)) dut (
    .clk(clk), .rst(rst), .rx_en_sig(rx_en_sig), .rx_pin(rx_pin),
    .rx_data(rx_data), .rx_done_sig(rx_done_sig), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_done_sig) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(cyc);
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if ((rx_done_sig && frame_err) || (rx_done_sig && done_prev) || (frame_err && err_prev))
      bad_pulse <= bad_pulse + 1;
    done_prev <= rx_done_sig;
    err_prev  <= frame_err;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Call at a negedge, and the task returns at a negedge. A bad stop is held
  // low for two bit times before the line returns high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int per, input int gap);
    rx_pin = 1'b0;
    start_cyc = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (per) @(negedge clk);
    end
    if (stop_ok) begin
      rx_pin = 1'b1;
      repeat (per) @(negedge clk);
    end else begin
      rx_pin = 1'b0;
      repeat (2 * per) @(negedge clk);
      rx_pin = 1'b1;
    end
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         per;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, e0, t;
    vecs[0] = '{8'h3C, 1'b0, 434, 0, 1, 8'h55};
    vecs[1] = '{8'h81, 1'b1, 434, 1, 0, 8'h81};
    vecs[2] = '{8'h55, 1'b1, 425, 1, 0, 8'h55};
    vecs[3] = '{8'hC3, 1'b1, 443, 1, 0, 8'hC3};
    vecs[4] = '{8'h6A, 1'b0, 425, 0, 1, 8'hC3};
    vecs[5] = '{8'h96, 1'b1, 443, 1, 0, 8'h96};

    rst = 1'b1; rx_en_sig = 1'b1; rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    check("reset rx_data", int'(rx_data), 0);
    check("reset rx_done_sig", int'(rx_done_sig), 0);
    check("reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single 0x55 frame, with exact latency. t0 comes two clks after the pin
    // edge, and the pulse arrives HALF+9*BPS+1 clks after t0.
    done_cyc.delete();
    send_frame(8'h55, 1'b1, P, P);
    check("case1 done count", done_cnt, 1);
    check("case1 frame_err count", err_cnt, 0);
    check("case1 rx_data", int'(rx_data), 8'h55);
    t = (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1;
    check("case1 done latency", t, 3 + P / 2 + 9 * P);

    // Table-driven frames: stop errors plus +/-2% TX skew.
    foreach (vecs[i]) begin
      d0 = done_cnt; e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].per, P);
      check($sformatf("vec%0d done count", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d frame_err count", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
    end

    // 100-clk low glitch on an idle line.
    d0 = done_cnt; e0 = err_cnt;
    rx_pin = 1'b0;
    repeat (100) @(negedge clk);
    rx_pin = 1'b1;
    repeat (P) @(negedge clk);
    check("glitch done count", done_cnt - d0, 0);
    check("glitch frame_err count", err_cnt - e0, 0);
    check("glitch rx_data", int'(rx_data), 8'h96);

    // Back-to-back frames with no idle gap.
    d0 = done_cnt;
    done_cyc.delete();
    send_frame(8'hA5, 1'b1, P, 0);
    check("b2b first rx_data", int'(rx_data), 8'hA5);
    send_frame(8'h0F, 1'b1, P, P);
    check("b2b done count", done_cnt - d0, 2);
    check("b2b second rx_data", int'(rx_data), 8'h0F);
    t = (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1;
    check("b2b pulse spacing", t, 10 * P);

    // Reset during bit 4 of 0xFF. After the start bit the line stays high.
    d0 = done_cnt; e0 = err_cnt;
    rx_pin = 1'b0;
    repeat (P) @(negedge clk);
    rx_pin = 1'b1;
    repeat (4 * P + P / 2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (5 * P) @(negedge clk);
    check("rst-abort done count", done_cnt - d0, 0);
    check("rst-abort frame_err count", err_cnt - e0, 0);
    check("rst-abort rx_data", int'(rx_data), 0);
    send_frame(8'h12, 1'b1, P, P);
    check("after rst rx_data", int'(rx_data), 8'h12);

    // Enable dropped in bit 3 and raised in bit 4 of 0x0F. The rest of that
    // frame has no falling edge, so nothing may re-trigger.
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'h0F, 1'b1, P, P);
      begin
        repeat (4 * P + P / 2) @(negedge clk);
        rx_en_sig = 1'b0;
        repeat (P) @(negedge clk);
        rx_en_sig = 1'b1;
      end
    join
    check("en-drop done count", done_cnt - d0, 0);
    check("en-drop frame_err count", err_cnt - e0, 0);
    check("en-drop rx_data", int'(rx_data), 8'h12);
    send_frame(8'h7E, 1'b1, P, P);
    check("after en rx_data", int'(rx_data), 8'h7E);
    check("after en done count", done_cnt - d0, 1);

    check("pulse overlap/width violations", bad_pulse, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
